// File: rtl/alu_op_issuer.sv
// alu_op_issuer: command FIFO + IDLE/EXEC/RESP sequencer that drives a
// combinational 16-bit ALU through registered inputs. It captures the ALU
// result and flags after one settle cycle and returns them, tagged, on a
// valid/ready response channel.
module alu_op_issuer #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [15:0]      cmd_a,
  input  logic [15:0]      cmd_b,
  input  logic [3:0]       cmd_opcode,
  input  logic [6:0]       cmd_shamt,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic [15:0]      alu_a,
  output logic [15:0]      alu_b,
  output logic [3:0]       alu_opcode,
  output logic [6:0]       alu_shift_amt,
  input  logic [15:0]      alu_result,
  input  logic [31:0]      alu_mul_result,
  input  logic             alu_carry,
  input  logic             alu_zero,
  input  logic             alu_neg,
  input  logic             alu_ovf,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic [3:0]       rsp_flags,
  output logic             rsp_err,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [15:0]      op_count,
  output logic             busy
);

  // Opcode whose response carries the full 32-bit product.
  localparam logic [3:0] OP_MUL = 4'd2;

  localparam int AW = $clog2(DEPTH);
  // Entry layout: {tag, shamt, opcode, b, a}
  localparam int EW = 16 + 16 + 4 + 7 + TAG_W;
  localparam logic [AW:0] PTR_ONE = 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [EW-1:0]    r_fifo_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic [EW-1:0]    w_push_entry;
  logic [EW-1:0]    w_head;

  logic             w_load;
  logic             w_capture;
  logic             w_rsp_done;

  logic [15:0]      r_alu_a;
  logic [15:0]      r_alu_b;
  logic [3:0]       r_alu_opcode;
  logic [6:0]       r_alu_shift_amt;
  logic [TAG_W-1:0] r_cur_tag;

  logic             r_rsp_valid;
  logic [31:0]      r_rsp_data;
  logic [3:0]       r_rsp_flags;
  logic             r_rsp_err;
  logic [TAG_W-1:0] r_rsp_tag;
  logic [15:0]      r_op_count;

  // Pointers carry one extra wrap bit: equal -> empty, only MSB differs -> full.
  assign w_empty      = (r_wr_ptr == r_rd_ptr);
  assign w_full       = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                        (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  // Readiness depends on fullness alone, so a pop never frees a slot for the same cycle.
  assign w_push       = cmd_valid && !w_full;
  assign w_push_entry = {cmd_tag, cmd_shamt, cmd_opcode, cmd_b, cmd_a};
  assign w_head       = r_fifo_mem[r_rd_ptr[AW-1:0]];

  // FIFO storage write; contents need no reset because the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_mem[r_wr_ptr[AW-1:0]] <= w_push_entry;
    end
  end

  // FIFO pointer update: push from the command port, pop whenever the FSM loads the ALU.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_load) r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state and control strobes (load/pop, capture, response handshake).
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_capture    = 1'b0;
    w_rsp_done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_load       = 1'b1;
          w_state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        w_capture    = 1'b1;
        w_state_next = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_rsp_done = 1'b1;
          if (!w_empty) begin
            w_load       = 1'b1;
            w_state_next = S_EXEC;
          end else begin
            w_state_next = S_IDLE;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // ALU input registers: loaded from the FIFO head, held stable otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_alu_a         <= '0;
      r_alu_b         <= '0;
      r_alu_opcode    <= '0;
      r_alu_shift_amt <= '0;
      r_cur_tag       <= '0;
    end else if (w_load) begin
      r_alu_a         <= w_head[15:0];
      r_alu_b         <= w_head[31:16];
      r_alu_opcode    <= w_head[35:32];
      r_alu_shift_amt <= w_head[42:36];
      r_cur_tag       <= w_head[EW-1:43];
    end
  end

  // Response capture after the settle cycle; fields stay frozen until the handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_flags <= '0;
      r_rsp_err   <= 1'b0;
      r_rsp_tag   <= '0;
    end else if (w_capture) begin
      r_rsp_valid <= 1'b1;
      r_rsp_data  <= (r_alu_opcode == OP_MUL) ? alu_mul_result : {16'h0000, alu_result};
      r_rsp_flags <= {alu_ovf, alu_neg, alu_zero, alu_carry};
      r_rsp_err   <= r_alu_opcode[3];
      r_rsp_tag   <= r_cur_tag;
    end else if (w_rsp_done) begin
      r_rsp_valid <= 1'b0;
    end
  end

  // Completed-response counter, free-running wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             r_op_count <= '0;
    else if (w_rsp_done) r_op_count <= r_op_count + 16'd1;
  end

  assign cmd_ready     = !w_full;
  assign alu_a         = r_alu_a;
  assign alu_b         = r_alu_b;
  assign alu_opcode    = r_alu_opcode;
  assign alu_shift_amt = r_alu_shift_amt;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_data      = r_rsp_data;
  assign rsp_flags     = r_rsp_flags;
  assign rsp_err       = r_rsp_err;
  assign rsp_tag       = r_rsp_tag;
  assign op_count      = r_op_count;
  assign busy          = (r_state != S_IDLE) || !w_empty;

endmodule
